// File: rtl/exu_posit_int2p_ctl.sv
// Multi-cycle integer-to-posit converter (fcvt.p.w / fcvt.p.wu).
// Normalizes with a log-step leading-zero shifter, then packs with round-to-nearest-even.
module exu_posit_int2p_ctl #(
    parameter int N  = 32,
    parameter int es = 2,
    localparam int Bs = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_l,
    input  logic         start,
    input  logic         flush,
    input  logic         is_unsigned,
    input  logic [N-1:0] in,
    output logic [N-1:0] out,
    output logic         done,
    output logic         busy
);

    localparam int SW = (Bs > 1) ? $clog2(Bs) : 1;
    localparam int TW = N + es;          // separator, exponent and fraction
    localparam int YW = (N - 1) + TW;    // widest regime plus tail

    typedef enum logic [1:0] {IDLE, NORM, PACK} state_t;

    state_t         state_reg, state_next;
    logic           sign_reg, sign_next;
    logic           zero_reg, zero_next;
    logic [N-1:0]   m_reg, m_next;
    logic [Bs-1:0]  cnt_reg, cnt_next;
    logic [SW-1:0]  step_reg, step_next;
    logic [N-1:0]   out_reg, out_next;
    logic           done_reg, done_next;

    logic           start_sign;
    logic [N-1:0]   start_mag;

    assign start_sign = ~is_unsigned & in[N-1];
    assign start_mag  = start_sign ? (N'(0) - in) : in;

    // One candidate shift per normalization step; the step counter picks which applies.
    logic [Bs-1:0]  top_zero;
    logic [N-1:0]   m_shift [Bs];
    logic [Bs-1:0]  step_inc;

    genvar gi;
    generate
        for (gi = 0; gi < Bs; gi++) begin : g_norm
            assign top_zero[gi] = ~|m_reg[N-1 -: (1 << gi)];
            assign m_shift[gi]  = m_reg << (1 << gi);
        end
    endgenerate

    assign step_inc = Bs'(1) << step_reg;

    logic [Bs-1:0]  k;
    logic [Bs-1:0]  r;
    logic [es-1:0]  e;
    logic [Bs:0]    rlen;
    logic [Bs:0]    rlen_c;
    logic [YW-1:0]  y;
    logic [N-2:0]   kept;
    logic           g_bit;
    logic           st_bit;
    logic           ulp;
    logic [N-2:0]   body;
    logic [N-1:0]   p_mag;
    logic [N-1:0]   p_res;

    assign k      = Bs'(N - 1) - cnt_reg;
    assign r      = k >> es;
    assign e      = k[es-1:0];
    assign rlen   = {1'b0, r} + (Bs+1)'(1);
    assign rlen_c = (rlen > (Bs+1)'(N - 1)) ? (Bs+1)'(N - 1) : rlen;

    // Left-shifting a field of N-1 ones drops the excess, leaving exactly r+1 regime ones on top.
    assign y      = {{(N-1){1'b1}}, 1'b0, e, m_reg[N-2:0]} << ((Bs+1)'(N - 1) - rlen_c);
    assign kept   = y[YW-1 -: N-1];
    assign g_bit  = y[YW-N];
    assign st_bit = |y[YW-N-1:0];
    assign ulp    = g_bit & (st_bit | kept[0]);
    assign body   = (ulp && !(&kept)) ? kept + (N-1)'(1) : kept;
    assign p_mag  = {1'b0, body};
    assign p_res  = zero_reg ? '0 : (sign_reg ? (N'(0) - p_mag) : p_mag);

    always_comb begin
        state_next = state_reg;
        sign_next  = sign_reg;
        zero_next  = zero_reg;
        m_next     = m_reg;
        cnt_next   = cnt_reg;
        step_next  = step_reg;
        out_next   = out_reg;
        done_next  = 1'b0;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    sign_next  = start_sign;
                    m_next     = start_mag;
                    zero_next  = (start_mag == '0);
                    cnt_next   = '0;
                    step_next  = SW'(Bs - 1);
                    state_next = NORM;
                end
            end
            NORM: begin
                if (top_zero[step_reg]) begin
                    m_next   = m_shift[step_reg];
                    cnt_next = cnt_reg + step_inc;
                end
                if (step_reg == '0) begin
                    state_next = PACK;
                end else begin
                    step_next = step_reg - SW'(1);
                end
            end
            PACK: begin
                out_next   = p_res;
                done_next  = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase

        if (flush) begin
            state_next = IDLE;
            done_next  = 1'b0;
            out_next   = out_reg;
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_reg <= IDLE;
            sign_reg  <= 1'b0;
            zero_reg  <= 1'b0;
            m_reg     <= '0;
            cnt_reg   <= '0;
            step_reg  <= '0;
            out_reg   <= '0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            sign_reg  <= sign_next;
            zero_reg  <= zero_next;
            m_reg     <= m_next;
            cnt_reg   <= cnt_next;
            step_reg  <= step_next;
            out_reg   <= out_next;
            done_reg  <= done_next;
        end
    end

    assign out  = out_reg;
    assign done = done_reg;
    assign busy = (state_reg != IDLE) | done_reg;

endmodule
